axis_out_packer: RTL and testbench

// - Parametrised successor to the output AXIS master stage, sitting between data_path result output and the M_AXIS port.
// - Packs PACK_RATIO IN_WIDTH-bit result words into one wide beat and buffers beats in a FIFO of FIFO_DEPTH.
// - Generates TLAST from the datapath's last flag or from a programmable beat count.
// - Provides almost-full backpressure, a sticky overflow flag and a frame-done pulse for the control unit.

---
 rtl/accel_pkg.sv | 24 ++
 rtl/axis_beat_fifo.sv | 63 ++++++
 rtl/axis_out_packer.sv | 156 +++++++++++++++
 tb/tb_axis_out_packer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared helpers for the accelerator output path: sizing function and lane byte geometry.
package accel_pkg;

  localparam int unsigned BYTE_W = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Number of TSTRB bits covering one packed lane of the given width.
  function automatic int unsigned lane_bytes(input int unsigned lane_width);
    return lane_width / BYTE_W;
  endfunction

endpackage

// File: rtl/axis_beat_fifo.sv
// Beat FIFO behind the packer: first-word-fall-through, register-based storage,
// synchronous clear with priority over push and pop.
module axis_beat_fifo
  import accel_pkg::*;
#(
  parameter int unsigned WIDTH = 73,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (level_q == (PTR_W + 1)'(DEPTH));
  assign empty    = (level_q == '0);
  // A full FIFO refuses the push even when the head leaves in the same cycle.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level_q <= level_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/axis_out_packer.sv
// Output AXIS master stage: packs datapath result words into wide beats, buffers them,
// generates TLAST (datapath flag or beat count) and reports overflow / frame completion.
module axis_out_packer
  import accel_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned PACK_RATIO = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AF_MARGIN  = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic [IN_WIDTH-1:0]              in_data,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic                             almost_full,
  input  logic                             cfg_auto_last_en,
  input  logic [CNT_WIDTH-1:0]             cfg_beats_per_frame,
  output logic [IN_WIDTH*PACK_RATIO-1:0]   M_AXIS_TDATA,
  output logic [IN_WIDTH*PACK_RATIO/8-1:0] M_AXIS_TSTRB,
  output logic                             M_AXIS_TVALID,
  output logic                             M_AXIS_TLAST,
  input  logic                             M_AXIS_TREADY,
  output logic [clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                             frame_done,
  output logic                             overflow_err,
  input  logic                             err_clear
);

  localparam int unsigned OUT_WIDTH  = IN_WIDTH * PACK_RATIO;
  localparam int unsigned STRB_WIDTH = OUT_WIDTH / 8;
  localparam int unsigned LANE_B     = lane_bytes(IN_WIDTH);
  localparam int unsigned LANE_W     = (PACK_RATIO > 1) ? clog2(PACK_RATIO) : 1;
  // Only lanes before the last one need storage; the last lane comes straight from in_data.
  localparam int unsigned PACK_W     = (PACK_RATIO > 1) ? PACK_RATIO - 1 : 1;
  localparam int unsigned ENTRY_W    = OUT_WIDTH + STRB_WIDTH + 1;

  logic [PACK_W-1:0][IN_WIDTH-1:0] pack_q;
  logic [LANE_W-1:0]               lane_idx_q;
  logic [CNT_WIDTH-1:0]            beat_cnt_q;
  logic                            frame_done_q;
  logic                            overflow_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ENTRY_W-1:0]    fifo_wdata;
  logic [ENTRY_W-1:0]    fifo_rdata;
  logic                  accept;
  logic                  auto_eff;
  logic                  lane_last;
  logic                  auto_last;
  logic                  beat_last;
  logic                  push;
  logic                  pop;
  logic [OUT_WIDTH-1:0]  beat_data;
  logic [STRB_WIDTH-1:0] beat_strb;

  assign in_ready  = !fifo_full;
  assign accept    = in_valid && in_ready;
  // A zero beat count means "no auto framing", so fall back to in_last.
  assign auto_eff  = cfg_auto_last_en && (cfg_beats_per_frame != '0);
  assign lane_last = (lane_idx_q == LANE_W'(PACK_RATIO - 1));
  assign auto_last = auto_eff && (beat_cnt_q == cfg_beats_per_frame - CNT_WIDTH'(1));
  assign beat_last = auto_eff ? auto_last : in_last;
  assign push      = accept && (lane_last || (in_last && !auto_eff));
  assign pop       = M_AXIS_TVALID && M_AXIS_TREADY;

  // Assemble the outgoing beat: stored lanes, the current word, zeros (and zero strobes) above it.
  always_comb begin
    beat_data = '0;
    beat_strb = '0;
    for (int l = 0; l < int'(PACK_RATIO) - 1; l++) begin
      if (LANE_W'(l) < lane_idx_q) begin
        beat_data[l*IN_WIDTH +: IN_WIDTH] = pack_q[l];
        beat_strb[l*LANE_B +: LANE_B]     = '1;
      end
    end
    for (int l = 0; l < int'(PACK_RATIO); l++) begin
      if (LANE_W'(l) == lane_idx_q) begin
        beat_data[l*IN_WIDTH +: IN_WIDTH] = in_data;
        beat_strb[l*LANE_B +: LANE_B]     = '1;
      end
    end
  end

  assign fifo_wdata = {beat_last, beat_strb, beat_data};

  axis_beat_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .push_data (fifo_wdata),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign M_AXIS_TVALID = !fifo_empty;
  assign M_AXIS_TDATA  = fifo_rdata[OUT_WIDTH-1:0];
  assign M_AXIS_TSTRB  = fifo_rdata[OUT_WIDTH +: STRB_WIDTH];
  assign M_AXIS_TLAST  = fifo_rdata[ENTRY_W-1];
  assign almost_full   = (fifo_level >= ($bits(fifo_level))'(FIFO_DEPTH - AF_MARGIN));
  assign frame_done    = frame_done_q;
  assign overflow_err  = overflow_q;

  // Lane position, partial-beat storage and auto-mode beat counter; dropped words leave them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_q     <= '0;
      lane_idx_q <= '0;
      beat_cnt_q <= '0;
    end else if (clear) begin
      lane_idx_q <= '0;
      beat_cnt_q <= '0;
    end else if (accept) begin
      if (push) begin
        lane_idx_q <= '0;
        if (auto_eff) begin
          beat_cnt_q <= auto_last ? '0 : beat_cnt_q + CNT_WIDTH'(1);
        end
      end else begin
        lane_idx_q <= lane_idx_q + LANE_W'(1);
        for (int l = 0; l < int'(PACK_W); l++) begin
          if (LANE_W'(l) == lane_idx_q) begin
            pack_q[l] <= in_data;
          end
        end
      end
    end
  end

  // Frame-done pulse follows the TLAST handshake; overflow is sticky and a new drop beats err_clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= pop && M_AXIS_TLAST;
      if (in_valid && !in_ready) begin
        overflow_q <= 1'b1;
      end else if (err_clear) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_out_packer.sv
// Randomised and directed bench for axis_out_packer with a queue-based reference model
// and a scoreboard monitor on the M_AXIS side.
module tb_axis_out_packer;

  localparam int unsigned IW    = 32;
  localparam int unsigned PR    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AFM   = 1;
  localparam int unsigned CW    = 16;
  localparam int unsigned OW    = IW * PR;
  localparam int unsigned SW    = OW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          almost_full;
  logic          cfg_auto_last_en = 1'b0;
  logic [CW-1:0] cfg_beats_per_frame = '0;
  logic [OW-1:0] tdata;
  logic [SW-1:0] tstrb;
  logic          tvalid;
  logic          tlast;
  logic          tready = 1'b1;
  logic [2:0]    fifo_level;
  logic          frame_done;
  logic          overflow_err;
  logic          err_clear = 1'b0;

  axis_out_packer #(
    .IN_WIDTH   (IW),
    .PACK_RATIO (PR),
    .FIFO_DEPTH (DEPTH),
    .AF_MARGIN  (AFM),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .clear               (clear),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_last             (in_last),
    .in_ready            (in_ready),
    .almost_full         (almost_full),
    .cfg_auto_last_en    (cfg_auto_last_en),
    .cfg_beats_per_frame (cfg_beats_per_frame),
    .M_AXIS_TDATA        (tdata),
    .M_AXIS_TSTRB        (tstrb),
    .M_AXIS_TVALID       (tvalid),
    .M_AXIS_TLAST        (tlast),
    .M_AXIS_TREADY       (tready),
    .fifo_level          (fifo_level),
    .frame_done          (frame_done),
    .overflow_err        (overflow_err),
    .err_clear           (err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  beat_t         sbq[$];   // beats the monitor expects, in order
  beat_t         mq[$];    // model of FIFO contents
  logic [IW-1:0] pend[$];  // words waiting to complete a beat
  int            n_checks = 0;
  int            n_fail = 0;
  int            frame_pos = 0;
  int            fd_seen = 0;
  logic          exp_fd = 1'b0;
  logic          exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: checks the visible state, then advances by one clock using the sampled inputs.
  logic  m_pop, m_acc, m_auto;
  beat_t m_b;
  int    m_bpf;
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      sbq.delete();
      pend.delete();
      frame_pos = 0;
      exp_fd    = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      chk("tvalid", 64'(tvalid), 64'(mq.size() > 0));
      chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
      chk("almost_full", 64'(almost_full), 64'(mq.size() >= DEPTH - AFM));
      chk("frame_done", 64'(frame_done), 64'(exp_fd));
      chk("overflow_err", 64'(overflow_err), 64'(exp_ovf));
      m_bpf  = int'(cfg_beats_per_frame);
      m_auto = cfg_auto_last_en && (m_bpf != 0);
      m_pop  = (mq.size() > 0) && tready;
      exp_fd = 1'b0;
      if (m_pop) exp_fd = mq[0].last;
      if (in_valid && mq.size() >= DEPTH) exp_ovf = 1'b1;
      else if (err_clear) exp_ovf = 1'b0;
      if (clear) begin
        mq.delete();
        sbq.delete();
        pend.delete();
        frame_pos = 0;
      end else begin
        m_acc = in_valid && (mq.size() < DEPTH);
        if (m_pop) void'(mq.pop_front());
        if (m_acc) begin
          pend.push_back(in_data);
          if (pend.size() == PR || (in_last && !m_auto)) begin
            m_b.data = '0;
            foreach (pend[i]) m_b.data = m_b.data | (OW'(pend[i]) << (IW * i));
            m_b.strb = SW'((64'(1) << ((IW / 8) * pend.size())) - 64'(1));
            if (m_auto) begin
              frame_pos++;
              m_b.last = (frame_pos % m_bpf) == 0;
              if (m_b.last) frame_pos = 0;
            end else begin
              m_b.last = in_last;
            end
            mq.push_back(m_b);
            sbq.push_back(m_b);
            pend.delete();
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stability while stalled.
  logic [OW-1:0] prev_data;
  logic [SW-1:0] prev_strb;
  logic          prev_last;
  logic          prev_stall = 1'b0;
  beat_t         mon_b;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_done) fd_seen++;
      if (prev_stall && tvalid) begin
        chk("tdata_stable", 64'(tdata), 64'(prev_data));
        chk("tstrb_stable", 64'(tstrb), 64'(prev_strb));
        chk("tlast_stable", 64'(tlast), 64'(prev_last));
      end
      if (tvalid && tready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_beat", 64'(sbq.size()), 64'(1));
        end else begin
          mon_b = sbq.pop_front();
          chk("beat_tdata", 64'(tdata), 64'(mon_b.data));
          chk("beat_tstrb", 64'(tstrb), 64'(mon_b.strb));
          chk("beat_tlast", 64'(tlast), 64'(mon_b.last));
        end
      end
      prev_stall = tvalid && !tready && !clear;
      prev_data  = tdata;
      prev_strb  = tstrb;
      prev_last  = tlast;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one word; with wait_rdy the word is held until accepted (bounded).
  task automatic send(input logic [IW-1:0] d, input logic l, input bit wait_rdy);
    int   guard;
    logic ok;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok || !wait_rdy) break;
      guard++;
      if (guard > 200) begin
        chk("send_timeout", 64'(guard), 64'(0));
        break;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard    = 0;
    in_valid = 1'b0;
    tready   = 1'b1;
    while (mq.size() != 0 && guard < 100) begin
      cyc(1);
      guard++;
    end
    if (guard >= 100) chk("drain_timeout", 64'(guard), 64'(0));
    cyc(2);
  endtask

  task automatic drain_and_clear();
    drain();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    cyc(1);
  endtask

  task automatic rand_phase(input int n, input logic auto_en, input int bpf);
    drain_and_clear();
    cfg_auto_last_en    = auto_en;
    cfg_beats_per_frame = CW'(bpf);
    for (int i = 0; i < n; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_last   = ($urandom_range(0, 4) == 0);
      tready    = ($urandom_range(0, 2) != 0);
      err_clear = ($urandom_range(0, 9) == 0);
      cyc(1);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    err_clear = 1'b0;
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int fd0;
  initial begin
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_almost_full", 64'(almost_full), 64'(0));
    chk("rst_tdata", 64'(tdata), 64'(0));
    chk("rst_tlast", 64'(tlast), 64'(0));
    chk("rst_overflow", 64'(overflow_err), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);

    // Two full beats, last flag on the fourth word.
    fd0 = fd_seen;
    send(32'h11, 1'b0, 1'b1);
    send(32'h22, 1'b0, 1'b1);
    send(32'h33, 1'b0, 1'b1);
    send(32'h44, 1'b1, 1'b1);
    drain();
    chk("t1_frame_done_count", 64'(fd_seen - fd0), 64'(1));

    // Partial beat flushed by in_last.
    send(32'hA, 1'b0, 1'b1);
    send(32'hB, 1'b0, 1'b1);
    send(32'hC, 1'b1, 1'b1);
    drain();

    // Backpressure: fill, stall, then release.
    tready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(32'h100 + IW'(i), (i == 9), 1'b1);
      end
      begin
        cyc(14);
        chk("t3_level_full", 64'(fifo_level), 64'(4));
        chk("t3_in_ready_low", 64'(in_ready), 64'(0));
        chk("t3_almost_full", 64'(almost_full), 64'(1));
        tready = 1'b1;
      end
    join
    drain();

    // Auto TLAST every 3 beats, in_last held low.
    drain_and_clear();
    cfg_auto_last_en    = 1'b1;
    cfg_beats_per_frame = CW'(3);
    fd0 = fd_seen;
    for (int i = 0; i < 12; i++) send(32'h200 + IW'(i), 1'b0, 1'b1);
    drain();
    chk("t4_frame_done_count", 64'(fd_seen - fd0), 64'(2));
    cfg_auto_last_en    = 1'b0;
    cfg_beats_per_frame = '0;

    // Overflow: drive a word while full, then clear the error.
    tready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h300 + IW'(i), 1'b0, 1'b1);
    send(32'hDEAD, 1'b0, 1'b0);
    chk("t5_overflow_set", 64'(overflow_err), 64'(1));
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
    chk("t5_overflow_cleared", 64'(overflow_err), 64'(0));
    drain();
    send(32'h3F0, 1'b1, 1'b1);
    drain();

    // Soft clear mid-frame: 2 beats queued plus one pending word.
    tready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h400 + IW'(i), 1'b0, 1'b1);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t6_clear_tvalid", 64'(tvalid), 64'(0));
    chk("t6_clear_level", 64'(fifo_level), 64'(0));
    send(32'h55, 1'b1, 1'b1);
    drain();

    // Async reset mid-frame.
    tready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h500 + IW'(i), 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", 64'(tvalid), 64'(0));
    chk("t6_rst_level", 64'(fifo_level), 64'(0));
    chk("t6_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);
    send(32'h66, 1'b1, 1'b1);
    drain();

    // Randomised traffic: in_last framing, auto framing, zero count falling back to in_last.
    rand_phase(400, 1'b0, 0);
    rand_phase(400, 1'b1, 3);
    rand_phase(300, 1'b1, 1);
    rand_phase(300, 1'b1, 0);

    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
